// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage PC source selector.
package pc_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_src_mux.sv
// NUM_SRC:1 combinational PC source mux with an out-of-range select flag.
module pc_src_mux
  import pc_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         data,
  output logic                      oor
);

  always_comb begin
    data = '0;
    oor  = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        data = src_data[i*DATA_W +: DATA_W];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_source_sel_epc.sv
// PC register with source select, interrupt entry, EPC capture and eret.
// Optional PC_ALIGN_CHECK_EN traps misaligned next-PC values.
module pc_source_sel_epc
  import pc_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_SRC    = 6,
  parameter int unsigned SEL_W      = $clog2(NUM_SRC),
  parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'(EXC_VECTOR_DEF),
  parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(RESET_PC_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      stall,
  input  logic                      intr_req,
  input  logic                      eret,
  output logic [DATA_W-1:0]         pc_out,
  output logic [DATA_W-1:0]         epc_out,
  output logic                      intr_ack,
  output logic                      in_handler,
  output logic                      sel_err
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                      misalign
`endif
);

  pc_state_e         state;
  logic              pending;
  logic [DATA_W-1:0] mux_data;
  logic              oor;
  logic [DATA_W-1:0] nxt;
  logic              algn;
  logic              take;
  logic              ret;

  pc_src_mux #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux (
    .src_data (src_data),
    .sel      (sel),
    .data     (mux_data),
    .oor      (oor)
  );

  always_comb begin
    nxt  = oor ? pc_out : mux_data;
    algn = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    algn = (nxt[1:0] != 2'b00);
`endif
    ret  = (state == HANDLER) && eret;
    take = (state == RUN) && !stall
           && (pending || intr_req || algn);
  end

  assign in_handler = (state == HANDLER);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out   <= RESET_PC;
      epc_out  <= '0;
      intr_ack <= 1'b0;
      sel_err  <= 1'b0;
      pending  <= 1'b0;
      state    <= RUN;
    end else begin
      intr_ack <= take;
      if (oor)
        sel_err <= 1'b1;
      // taking the interrupt consumes the request
      if (take)
        pending <= 1'b0;
      else if (intr_req)
        pending <= 1'b1;
      if (ret) begin
        pc_out <= epc_out;
        state  <= RUN;
      end else if (take) begin
        pc_out  <= EXC_VECTOR;
        epc_out <= nxt;
        state   <= HANDLER;
      end else if (!stall) begin
        pc_out <= nxt;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      misalign <= 1'b0;
    else if (ret)
      misalign <= 1'b0;
    else if (take)
      misalign <= algn;
  end
`endif

endmodule

// File: doc/pc_source_sel_epc.md
Name: pc_source_sel_epc

Overview:
Parametrised successor to the 6:1 PC-source multiplexer with INTT/EPC. It selects the next PC from NUM_SRC sources and holds it in a PC register. It also latches interrupt requests, redirects to an exception vector, and captures the EPC in a register. It returns from the handler on eret. Sits in the IF stage of the pipelined MIPS CPU and feeds instruction memory and the IF/ID register.

Parameters:
DATA_W, 32, PC/data width
NUM_SRC, 6, number of PC sources (>=2)
SEL_W, $clog2(NUM_SRC), select width
EXC_VECTOR, 32'h0000_0080, handler entry address
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
src_data  in  NUM_SRC*DATA_W  flattened sources; source i = bits [i*DATA_W +: DATA_W]
sel  in  SEL_W  source select
stall  in  1  hold PC (hazard unit)
intr_req  in  1  interrupt request, level
eret  in  1  return from exception
pc_out  out  DATA_W  registered current PC
epc_out  out  DATA_W  registered exception PC
intr_ack  out  1  one-cycle pulse when interrupt is taken
in_handler  out  1  high while state=HANDLER
sel_err  out  1  sticky: sel >= NUM_SRC seen

Behaviour:
- Reset (synchronous, active-high, one clock): pc_out=RESET_PC, epc_out=0, intr_ack=0, in_handler=0, sel_err=0, pending=0, state=RUN.
- nxt = src_data[sel] (combinational). If sel >= NUM_SRC: nxt = pc_out (hold) and sel_err is set on the next edge. sel_err is cleared only by rst.
- pending latch:
  - Set on any edge where intr_req=1.
  - Cleared on the edge where the interrupt is taken.
  - Requests arriving during stall or HANDLER are therefore remembered, not dropped.
- States: RUN, HANDLER. Per-edge priority: rst > eret > interrupt > stall > normal.
- RUN, (pending|intr_req)=1, stall=0:
  - pc_out <= EXC_VECTOR.
  - epc_out <= nxt.
  - intr_ack=1 for that one cycle.
  - Go to HANDLER.
- RUN, stall=1: pc_out and epc_out hold. No interrupt is taken; pending stays set. The interrupt is taken on the first unstalled edge.
- RUN, normal: pc_out <= nxt. One-cycle latency from sel/src_data to pc_out.
- HANDLER: pc_out <= nxt (the handler runs normally). Interrupts are not nested; pending may set but no new interrupt is taken.
- HANDLER with eret=1 (stall ignored):
  - pc_out <= epc_out; go to RUN.
  - If pending=1 on that edge, the interrupt is taken on the next unstalled RUN edge, no earlier.
- eret in RUN: ignored (normal update).
- intr_ack is never high two cycles in a row. in_handler is a registered decode of state.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - Extra output misalign (1 bit, reset 0).
  - In RUN with stall=0, if nxt[1:0]!=0, treat the edge as an interrupt: pc_out <= EXC_VECTOR, epc_out <= nxt, intr_ack=1, HANDLER, misalign=1.
  - misalign clears on eret.
  - If a real interrupt coincides, both are taken in one entry and misalign=1.
- Undefined: no port; misaligned addresses pass through unchecked.

Decomposition:
- Shared package pc_pkg: state enum {RUN, HANDLER}, default EXC_VECTOR and RESET_PC constants, DATA_W default.
- One natural sub-module: pc_src_mux (parametrised NUM_SRC:1 combinational mux with out-of-range flag). The top level holds the PC/EPC registers, pending latch and FSM.

Test Plan:
- Reset then sel=2 with sources {0,0,3,7,1,0}: after 1 edge pc_out=3; sel=3 -> pc_out=7.
- RUN, nxt=0x40, intr_req pulse 1 cycle: next edge pc_out=0x80, epc_out=0x40, intr_ack=1 for one cycle, in_handler=1.
- intr_req pulse while stall=1 for 3 cycles: pc_out frozen, no ack. First unstalled edge: pc_out=0x80, epc_out=nxt.
- In HANDLER, intr_req pulse, then eret: pc_out=0x40, RUN. The following edge takes the pending interrupt (pc_out=0x80).
- NUM_SRC=6, sel=7: pc_out holds and sel_err=1 stays set until rst. rst mid-HANDLER -> pc_out=0, state RUN, epc_out=0.
- PC_ALIGN_CHECK_EN defined, nxt=0x42: pc_out=0x80, epc_out=0x42, misalign=1. eret -> misalign=0.
